// File: rtl/crgu_pkg.sv
// Shared types and default timing for the crgu power sequencer.
package crgu_pkg;

  localparam int unsigned OSC_SETTLE_CYC_DEF = 16;
  localparam int unsigned EFUSE_TO_CYC_DEF   = 64;
  localparam int unsigned GAP_CYC_DEF        = 2;
  localparam int unsigned FIFO_RST_CYC_DEF   = 4;
  localparam int unsigned CNT_W_DEF          = 8;
  localparam int unsigned STATE_W            = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_OSC_UP  = 3'd1,
    ST_EFUSE   = 3'd2,
    ST_CORE_UP = 3'd3,
    ST_SLOT_UP = 3'd4,
    ST_ACTIVE  = 3'd5,
    ST_SLOT_DN = 3'd6,
    ST_CORE_DN = 3'd7
  } state_e;

  // Gating / reset levels owned by the sequencer; fifo_rstn is the base level before any soft pulse.
  typedef struct packed {
    logic osc13m;
    logic efuse;
    logic timer;
    logic data;
    logic slot;
    logic shut_rstn;
    logic fifo_rstn;
  } en_t;

endpackage

// File: rtl/crgu_rst_pulse.sv
// Counter-based low-pulse generator; lo_c is the next-cycle "pulse active" level.
module crgu_rst_pulse #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_32k,
  input  logic             rst_32k,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             lo_c
);

  logic             active_q, active_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  always_ff @(posedge clk_32k or posedge rst_32k) begin
    if (rst_32k) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  // Triggers while a pulse is running are dropped; abort wins over everything.
  always_comb begin
    active_nxt = active_q;
    cnt_nxt    = cnt_q;
    if (abort) begin
      active_nxt = 1'b0;
      cnt_nxt    = '0;
    end else if (active_q) begin
      if (cnt_q == len - CNT_W'(1)) begin
        active_nxt = 1'b0;
        cnt_nxt    = '0;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end else if (trig) begin
      active_nxt = 1'b1;
      cnt_nxt    = '0;
    end
  end

  assign lo_c = active_nxt;

endmodule

// File: rtl/crgu_pwr_seq.sv
// Always-on power-up/down sequencer for crgu clock enables and soft resets.
module crgu_pwr_seq
  import crgu_pkg::*;
#(
  parameter int unsigned OSC_SETTLE_CYC = OSC_SETTLE_CYC_DEF,
  parameter int unsigned EFUSE_TO_CYC   = EFUSE_TO_CYC_DEF,
  parameter int unsigned GAP_CYC        = GAP_CYC_DEF,
  parameter int unsigned FIFO_RST_CYC   = FIFO_RST_CYC_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic         clk_32k,
  input  logic         rst_32k,
  input  logic         rg_top_start,
  input  logic         efuse_done,
  input  logic         fifo_rst_req,
  output logic         osc13m_clk_en,
  output logic         efuse_clk_en,
  output logic         timer_clk_en,
  output logic         data_clk_en,
  output logic         slot_clk_en,
  output logic         shut_rstn,
  output logic         pmu_fifo_rstn,
  output logic         seq_busy,
  output logic [2:0]   seq_state,
  output logic         efuse_timeout
);

  localparam logic [CNT_W-1:0] OSC_LAST   = CNT_W'(OSC_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] EFUSE_LAST = CNT_W'(EFUSE_TO_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  en_t              en_q, en_nxt;
  logic             tmo_q, tmo_nxt;
  logic             busy_q, busy_nxt;
  logic             pmu_q, pmu_nxt;
  logic             pulse_lo_c;
  logic             pulse_trig, pulse_abort;

  always_ff @(posedge clk_32k or posedge rst_32k) begin
    if (rst_32k) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      pmu_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      en_q    <= en_nxt;
      tmo_q   <= tmo_nxt;
      busy_q  <= busy_nxt;
      pmu_q   <= pmu_nxt;
    end
  end

  // Output levels change on the edge that enters the new state; stop aborts take priority over hold expiry.
  always_comb begin
    state_nxt = state_q;
    en_nxt    = en_q;
    tmo_nxt   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (rg_top_start) begin
          state_nxt     = ST_OSC_UP;
          en_nxt.osc13m = 1'b1;
          tmo_nxt       = 1'b0;
        end
      end
      ST_OSC_UP: begin
        if (!rg_top_start) begin
          state_nxt    = ST_CORE_DN;
          en_nxt.efuse = 1'b0;
        end else if (cnt_q == OSC_LAST) begin
          state_nxt    = ST_EFUSE;
          en_nxt.efuse = 1'b1;
        end
      end
      ST_EFUSE: begin
        if (!rg_top_start) begin
          state_nxt    = ST_CORE_DN;
          en_nxt.efuse = 1'b0;
        end else if (efuse_done || (cnt_q == EFUSE_LAST)) begin
          state_nxt    = ST_CORE_UP;
          en_nxt.efuse = 1'b0;
          en_nxt.timer = 1'b1;
          en_nxt.data  = 1'b1;
          if (!efuse_done) tmo_nxt = 1'b1;
        end
      end
      ST_CORE_UP: begin
        if (!rg_top_start) begin
          state_nxt   = ST_SLOT_DN;
          en_nxt.slot = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          state_nxt        = ST_SLOT_UP;
          en_nxt.shut_rstn = 1'b1;
          en_nxt.fifo_rstn = 1'b1;
        end
      end
      ST_SLOT_UP: begin
        if (!rg_top_start) begin
          state_nxt   = ST_SLOT_DN;
          en_nxt.slot = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          state_nxt   = ST_ACTIVE;
          en_nxt.slot = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!rg_top_start) begin
          state_nxt   = ST_SLOT_DN;
          en_nxt.slot = 1'b0;
        end
      end
      ST_SLOT_DN: begin
        if (cnt_q == GAP_LAST) begin
          state_nxt        = ST_CORE_DN;
          en_nxt.shut_rstn = 1'b0;
          en_nxt.fifo_rstn = 1'b0;
        end
      end
      ST_CORE_DN: begin
        if (cnt_q == GAP_LAST) begin
          state_nxt = ST_IDLE;
          en_nxt    = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        en_nxt    = '0;
      end
    endcase

    if (state_nxt != state_q) begin
      cnt_nxt = '0;
    end else if (cnt_q != '1) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end else begin
      cnt_nxt = cnt_q;
    end

    busy_nxt = !((state_nxt == ST_IDLE) || (state_nxt == ST_ACTIVE));
    pmu_nxt  = en_nxt.fifo_rstn & ~pulse_lo_c;
  end

  assign pulse_trig  = fifo_rst_req && (state_q == ST_ACTIVE);
  assign pulse_abort = (state_nxt != ST_ACTIVE);

  crgu_rst_pulse #(
    .CNT_W (CNT_W)
  ) u_fifo_pulse (
    .clk_32k (clk_32k),
    .rst_32k (rst_32k),
    .trig    (pulse_trig),
    .len     (CNT_W'(FIFO_RST_CYC)),
    .abort   (pulse_abort),
    .lo_c    (pulse_lo_c)
  );

  assign osc13m_clk_en = en_q.osc13m;
  assign efuse_clk_en  = en_q.efuse;
  assign timer_clk_en  = en_q.timer;
  assign data_clk_en   = en_q.data;
  assign slot_clk_en   = en_q.slot;
  assign shut_rstn     = en_q.shut_rstn;
  assign pmu_fifo_rstn = pmu_q;
  assign seq_busy      = busy_q;
  assign seq_state     = state_q;
  assign efuse_timeout = tmo_q;

endmodule

// File: tb/tb_crgu_pwr_seq.sv
// Scoreboard bench for crgu_pwr_seq: timeline expectations queued per scenario, compared on the falling edge.
module tb_crgu_pwr_seq;

  logic       clk_32k = 1'b0;
  logic       rst_32k;
  logic       rg_top_start;
  logic       efuse_done;
  logic       fifo_rst_req;
  logic       osc13m_clk_en, efuse_clk_en, timer_clk_en, data_clk_en, slot_clk_en;
  logic       shut_rstn, pmu_fifo_rstn, seq_busy, efuse_timeout;
  logic [2:0] seq_state;
  logic [11:0] obs;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;
  int          osc_entry;

  typedef struct {
    int          cyc;
    logic [11:0] val;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t x;

  crgu_pwr_seq dut (
    .clk_32k       (clk_32k),
    .rst_32k       (rst_32k),
    .rg_top_start  (rg_top_start),
    .efuse_done    (efuse_done),
    .fifo_rst_req  (fifo_rst_req),
    .osc13m_clk_en (osc13m_clk_en),
    .efuse_clk_en  (efuse_clk_en),
    .timer_clk_en  (timer_clk_en),
    .data_clk_en   (data_clk_en),
    .slot_clk_en   (slot_clk_en),
    .shut_rstn     (shut_rstn),
    .pmu_fifo_rstn (pmu_fifo_rstn),
    .seq_busy      (seq_busy),
    .seq_state     (seq_state),
    .efuse_timeout (efuse_timeout)
  );

  always #5 clk_32k = ~clk_32k;
  always @(posedge clk_32k) cyc <= cyc + 1;

  assign obs = {efuse_timeout, seq_state, seq_busy, pmu_fifo_rstn, shut_rstn,
                slot_clk_en, data_clk_en, timer_clk_en, efuse_clk_en, osc13m_clk_en};

  // Expected output word; busy follows from the state encoding (only IDLE=0 and ACTIVE=5 are not busy).
  function automatic logic [11:0] v(input logic tmo, input logic [2:0] st, input logic pmu,
                                    input logic shut, input logic slot, input logic data,
                                    input logic timer, input logic efuse, input logic osc);
    logic busy;
    busy = !((st == 3'd0) || (st == 3'd5));
    return {tmo, st, busy, pmu, shut, slot, data, timer, efuse, osc};
  endfunction

  task automatic push(input int c, input logic [11:0] val, input int id);
    exp_t e;
    e.cyc = c;
    e.val = val;
    e.id  = id;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    int k;
    rst_32k = 1'b1; rg_top_start = 1'b0; efuse_done = 1'b0; fifo_rst_req = 1'b0;
    repeat (3) @(negedge clk_32k);
    total++;
    if (obs !== 12'd0) begin
      bad++; $display("FAIL reset_hold got=%b want=%b", obs, 12'd0);
    end
    rst_32k = 1'b0;
    k = cyc + 1;
    push(k, 12'd0, 0);
    push(k + 1, 12'd0, 1);
    for (int g = 0; g < 50 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL reset id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL reset timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_power_up();
    int k;
    @(negedge clk_32k);
    efuse_done = 1'b1; rg_top_start = 1'b1;
    k = cyc + 1;
    push(k,      v(0, 3'd1, 0, 0, 0, 0, 0, 0, 1), 0);
    push(k + 15, v(0, 3'd1, 0, 0, 0, 0, 0, 0, 1), 1);
    push(k + 16, v(0, 3'd2, 0, 0, 0, 0, 0, 1, 1), 2);
    push(k + 17, v(0, 3'd3, 0, 0, 0, 1, 1, 0, 1), 3);
    push(k + 18, v(0, 3'd3, 0, 0, 0, 1, 1, 0, 1), 4);
    push(k + 19, v(0, 3'd4, 1, 1, 0, 1, 1, 0, 1), 5);
    push(k + 20, v(0, 3'd4, 1, 1, 0, 1, 1, 0, 1), 6);
    push(k + 21, v(0, 3'd5, 1, 1, 1, 1, 1, 0, 1), 7);
    for (int g = 0; g < 100 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL power_up id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL power_up timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_fifo_reset();
    int e;
    @(negedge clk_32k);
    fifo_rst_req = 1'b1;
    e = cyc + 1;
    push(e,     v(0, 3'd5, 0, 1, 1, 1, 1, 0, 1), 0);
    push(e + 1, v(0, 3'd5, 0, 1, 1, 1, 1, 0, 1), 1);
    push(e + 3, v(0, 3'd5, 0, 1, 1, 1, 1, 0, 1), 2);
    push(e + 4, v(0, 3'd5, 1, 1, 1, 1, 1, 0, 1), 3);
    push(e + 5, v(0, 3'd5, 1, 1, 1, 1, 1, 0, 1), 4);
    push(e + 6, v(0, 3'd5, 1, 1, 1, 1, 1, 0, 1), 5);
    for (int g = 0; g < 50 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      fifo_rst_req = (cyc == e + 1);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL fifo_pulse id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    fifo_rst_req = 1'b0;
    if (sb.size() != 0) begin total++; bad++; $display("FAIL fifo_pulse timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_power_down();
    int m;
    @(negedge clk_32k);
    rg_top_start = 1'b0;
    m = cyc + 1;
    push(m,     v(0, 3'd6, 1, 1, 0, 1, 1, 0, 1), 0);
    push(m + 1, v(0, 3'd6, 1, 1, 0, 1, 1, 0, 1), 1);
    push(m + 2, v(0, 3'd7, 0, 0, 0, 1, 1, 0, 1), 2);
    push(m + 3, v(0, 3'd7, 0, 0, 0, 1, 1, 0, 1), 3);
    push(m + 4, v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0), 4);
    push(m + 5, v(0, 3'd1, 0, 0, 0, 0, 0, 0, 1), 5);
    osc_entry = m + 5;
    for (int g = 0; g < 50 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      if (cyc == m + 1) rg_top_start = 1'b1;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL power_down id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL power_down timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_abort();
    int a;
    a = osc_entry;
    for (int i = 1; i <= 4; i++) push(a + i, v(0, 3'd1, 0, 0, 0, 0, 0, 0, 1), i);
    push(a + 5, v(0, 3'd7, 0, 0, 0, 0, 0, 0, 1), 5);
    push(a + 6, v(0, 3'd7, 0, 0, 0, 0, 0, 0, 1), 6);
    push(a + 7, v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0), 7);
    push(a + 8, v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0), 8);
    for (int g = 0; g < 50 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      if (cyc == a + 4) rg_top_start = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL abort id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL abort timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_efuse_timeout();
    int k, m;
    @(negedge clk_32k);
    efuse_done = 1'b0; rg_top_start = 1'b1;
    k = cyc + 1;
    push(k,      v(0, 3'd1, 0, 0, 0, 0, 0, 0, 1), 0);
    push(k + 16, v(0, 3'd2, 0, 0, 0, 0, 0, 1, 1), 1);
    push(k + 79, v(0, 3'd2, 0, 0, 0, 0, 0, 1, 1), 2);
    push(k + 80, v(1, 3'd3, 0, 0, 0, 1, 1, 0, 1), 3);
    push(k + 82, v(1, 3'd4, 1, 1, 0, 1, 1, 0, 1), 4);
    push(k + 84, v(1, 3'd5, 1, 1, 1, 1, 1, 0, 1), 5);
    for (int g = 0; g < 150 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL efuse_tmo id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL efuse_tmo timeout pending=%0d want=0", sb.size()); sb.delete(); end

    // Flag survives power-down, clears on restart, and an abort does not set it again.
    @(negedge clk_32k);
    rg_top_start = 1'b0;
    m = cyc + 1;
    push(m + 4,  v(1, 3'd0, 0, 0, 0, 0, 0, 0, 0), 10);
    push(m + 5,  v(1, 3'd0, 0, 0, 0, 0, 0, 0, 0), 11);
    push(m + 6,  v(0, 3'd1, 0, 0, 0, 0, 0, 0, 1), 12);
    push(m + 8,  v(0, 3'd7, 0, 0, 0, 0, 0, 0, 1), 13);
    push(m + 10, v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0), 14);
    for (int g = 0; g < 50 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      if (cyc == m + 5) rg_top_start = 1'b1;
      else if (cyc == m + 7) rg_top_start = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL tmo_sticky id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL tmo_sticky timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_idle_fifo();
    int i;
    @(negedge clk_32k);
    fifo_rst_req = 1'b1;
    i = cyc + 1;
    for (int j = 0; j < 6; j++) push(i + j, 12'd0, j);
    for (int g = 0; g < 50 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      fifo_rst_req = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL idle_fifo id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL idle_fifo timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_async_reset();
    int k;
    @(negedge clk_32k);
    efuse_done = 1'b1; rg_top_start = 1'b1;
    k = cyc + 1;
    push(k + 21, v(0, 3'd5, 1, 1, 1, 1, 1, 0, 1), 0);
    for (int g = 0; g < 60 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL async_pre id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL async_pre timeout pending=%0d want=0", sb.size()); sb.delete(); end

    #2 rst_32k = 1'b1;
    #1;
    total++;
    if (obs !== 12'd0) begin bad++; $display("FAIL async_now got=%b want=%b", obs, 12'd0); end
    total++;
    if (seq_state !== 3'd0) begin bad++; $display("FAIL async_state got=%0d want=0", seq_state); end
    @(negedge clk_32k);
    total++;
    if (obs !== 12'd0) begin bad++; $display("FAIL async_held got=%b want=%b", obs, 12'd0); end
    rst_32k = 1'b0;
    k = cyc + 1;
    push(k, v(0, 3'd1, 0, 0, 0, 0, 0, 0, 1), 1);
    for (int g = 0; g < 20 && sb.size() != 0; g++) begin
      @(negedge clk_32k);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front(); total++;
        if (obs !== x.val) begin bad++; $display("FAIL async_post id=%0d cyc=%0d got=%b want=%b", x.id, cyc, obs, x.val); end
      end
    end
    if (sb.size() != 0) begin total++; bad++; $display("FAIL async_post timeout pending=%0d want=0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_fifo_reset();
    test_power_down();
    test_abort();
    test_efuse_timeout();
    test_idle_fifo();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
